// File: rtl/vga_pxl_unpacker.sv
`default_nettype none
// ============================================================================
// Module      : vga_pxl_unpacker
// Description : Buffers AXI read-data words from the memory controller in a
//               small word FIFO, unpacks each word into pixels (LSB slot
//               first), and hands one registered pixel to the VGA timing
//               stage per request. Decouples bursty memory reads from the
//               steady pixel rate.
// Ports       : clk, rst            - clock, synchronous active-high reset
//               s_data_i/s_resp_i   - read data word and its RRESP
//               s_valid_i/s_rdy_o   - word handshake
//               frame_start_i       - per-frame flush pulse
//               pxl_req_i           - next-pixel request from timing stage
//               pxl_o/pxl_valid_o   - registered pixel and its qualifier
//               underflow_o         - sticky: request with no pixel ready
//               err_o               - sticky: an errored word was received
//               level_o             - words held in the FIFO
// Revision    : 1.0 - initial release
// ============================================================================
module vga_pxl_unpacker #(
  parameter int DATA_WIDTH = 64,
  parameter int PXL_WIDTH  = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [DATA_WIDTH-1:0]         s_data_i,
  input  logic [1:0]                    s_resp_i,
  input  logic                          s_valid_i,
  output logic                          s_rdy_o,
  input  logic                          frame_start_i,
  input  logic                          pxl_req_i,
  output logic [PXL_WIDTH-1:0]          pxl_o,
  output logic                          pxl_valid_o,
  output logic                          underflow_o,
  output logic                          err_o,
  output logic [$clog2(FIFO_DEPTH):0]   level_o
);

  localparam int c_ppw    = DATA_WIDTH / PXL_WIDTH;
  localparam int c_slot_w = (c_ppw > 1) ? $clog2(c_ppw) : 1;
  localparam int c_ptr_w  = $clog2(FIFO_DEPTH);
  localparam int c_cnt_w  = c_ptr_w + 1;

  localparam logic [c_slot_w-1:0] c_last_slot = c_slot_w'(c_ppw - 1);
  localparam logic [c_cnt_w-1:0]  c_full_cnt  = c_cnt_w'(FIFO_DEPTH);

  typedef enum logic [0:0] {
    ST_EMPTY  = 1'b0,
    ST_LOADED = 1'b1
  } state_t;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic [c_ptr_w-1:0]    r_wr_ptr;
  logic [c_ptr_w-1:0]    r_rd_ptr;
  logic [c_cnt_w-1:0]    r_count;
  logic [DATA_WIDTH-1:0] r_word;
  logic [c_slot_w-1:0]   r_slot;
  state_t                r_state;
  logic [PXL_WIDTH-1:0]  r_pxl;
  logic                  r_pxl_valid;
  logic                  r_underflow;
  logic                  r_err;

  logic                  w_full;
  logic                  w_empty;
  logic                  w_rdy;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_last;
  logic                  w_resp_err;
  logic [DATA_WIDTH-1:0] w_wdata;
  logic [PXL_WIDTH-1:0]  w_pxl;

  // --------------------------------------------------------------------------
  // Handshake and pop decision
  // --------------------------------------------------------------------------
  always_comb begin
    w_full     = (r_count == c_full_cnt);
    w_empty    = (r_count == '0);
    // Ready comes from the registered count only, so it never depends on
    // s_valid_i; reset and frame flush block acceptance in their own cycle.
    w_rdy      = !w_full && !rst && !frame_start_i;
    w_push     = s_valid_i && w_rdy;
    w_last     = (r_slot == c_last_slot);
    w_resp_err = (s_resp_i != 2'b00);
    // Errored words are stored as zeros so they display as black.
    w_wdata    = w_resp_err ? '0 : s_data_i;
    w_pxl      = r_word[r_slot*PXL_WIDTH +: PXL_WIDTH];

    // Pop decision uses the count before this cycle's push, so a word
    // arriving now cannot be loaded in the same cycle.
    w_pop = 1'b0;
    if (!frame_start_i && !w_empty) begin
      case (r_state)
        ST_EMPTY:  w_pop = 1'b1;
        ST_LOADED: w_pop = pxl_req_i && w_last;
        default:   w_pop = 1'b0;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Word storage (no reset needed: entries are only read after being written)
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= w_wdata;
    end
  end

  // --------------------------------------------------------------------------
  // FIFO bookkeeping and unpack FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst || frame_start_i) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_word      <= '0;
      r_slot      <= '0;
      r_state     <= ST_EMPTY;
      r_pxl       <= '0;
      r_pxl_valid <= 1'b0;
      r_underflow <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_pxl       <= '0;
      r_pxl_valid <= 1'b0;

      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
        if (w_resp_err) begin
          r_err <= 1'b1;
        end
      end

      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
        r_word   <= r_mem[r_rd_ptr];
      end

      r_count <= r_count + c_cnt_w'(w_push) - c_cnt_w'(w_pop);

      case (r_state)
        ST_EMPTY: begin
          // The load cycle itself cannot serve a request.
          if (pxl_req_i) begin
            r_underflow <= 1'b1;
          end
          if (!w_empty) begin
            r_slot  <= '0;
            r_state <= ST_LOADED;
          end
        end
        ST_LOADED: begin
          if (pxl_req_i) begin
            r_pxl       <= w_pxl;
            r_pxl_valid <= 1'b1;
            if (w_last) begin
              // Back-to-back words keep the stream gap-free.
              r_slot <= '0;
              if (w_empty) begin
                r_state <= ST_EMPTY;
              end
            end else begin
              r_slot <= r_slot + 1'b1;
            end
          end
        end
        default: r_state <= ST_EMPTY;
      endcase
    end
  end

  assign s_rdy_o     = w_rdy;
  assign pxl_o       = r_pxl;
  assign pxl_valid_o = r_pxl_valid;
  assign underflow_o = r_underflow;
  assign err_o       = r_err;
  assign level_o     = r_count;

endmodule
`default_nettype wire
